// File: rtl/lab7_soc_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit OCI trace symbols into 30-bit frames (15 symbols) behind a one-entry output slot.
// Optional refused-symbol counter enabled by defining OCI_DCT_DROP_CNT_EN.
module lab7_soc_nios2_qsys_0_oci_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [1:0]  sym,
    output logic        sym_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [33:0] out_data,
    input  logic        out_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_ending,
    output logic        test_has_ended
`ifdef OCI_DCT_DROP_CNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
    state_t state;

    logic        accept;
    logic        slot_free;
    logic        xfer;
    logic [29:0] nbuf;
    logic [3:0]  ncnt;

    assign test_ending    = (state != ACCUM);
    assign test_has_ended = (state == DONE);

    assign sym_ready = (state == ACCUM) && (dct_count != 4'd15);
    assign accept    = sym_valid && sym_ready;
    assign nbuf      = accept ? {dct_buffer[27:0], sym} : dct_buffer;
    assign ncnt      = dct_count + {3'd0, accept};
    assign slot_free = !out_valid || out_ready;
    // A full frame always goes out; while draining, any partial frame does too.
    assign xfer      = slot_free && ((ncnt == 4'd15) || ((state != ACCUM) && (ncnt != 4'd0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            dct_buffer <= '0;
            dct_count  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (xfer) begin
                out_data   <= {ncnt, nbuf};
                out_valid  <= 1'b1;
                dct_buffer <= '0;
                dct_count  <= '0;
            end else begin
                dct_buffer <= nbuf;
                dct_count  <= ncnt;
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
            case (state)
                ACCUM:   if (flush) state <= DRAIN;
                DRAIN:   if (dct_count == 4'd0 && !out_valid) state <= DONE;
                default: state <= DONE;
            endcase
        end
    end

`ifdef OCI_DCT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (sym_valid && !sym_ready && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_lab7_soc_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: stimulus pushes expected frames, a negedge monitor pops and compares.
module tb_lab7_soc_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sym_valid;
    logic [1:0]  sym;
    logic        sym_ready;
    logic        flush;
    logic        out_valid;
    logic [33:0] out_data;
    logic        out_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
`ifdef OCI_DCT_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_exp;

    lab7_soc_nios2_qsys_0_oci_dct_packer dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended)
`ifdef OCI_DCT_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a frame is consumed whenever the slot handshakes on the coming edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got %h expected none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("frame", out_data, mon_exp);
            end
        end
    end

    initial begin
        int k;
        reset = 1'b1; sym_valid = 1'b0; sym = 2'd0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_buffer", dct_buffer, 0);
        chk("rst_count", dct_count, 0);
        chk("rst_ending", test_ending, 0);
        chk("rst_ended", test_has_ended, 0);
        reset = 1'b0;
        step();
        chk("rst_sym_ready", sym_ready, 1);

        // Full frame at full rate
        out_ready = 1'b1;
        exp_q.push_back({4'd15, 30'h06C6C6C6});
        sym_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sym = 2'(i % 4);
            step();
        end
        sym_valid = 1'b0;
        chk("full_out_valid", out_valid, 1);
        chk("full_count", dct_count, 0);
        step();
        chk("full_slot_empty", out_valid, 0);

        // Backpressure: 30 symbols, second frame held in accumulator
        out_ready = 1'b0;
        exp_q.push_back({4'd15, 30'h2AAAAAAA});
        exp_q.push_back({4'd15, 30'h39393939});
        k = 0;
        sym_valid = 1'b1;
        for (int c = 0; c < 60 && k < 30; c++) begin
            sym = (k < 15) ? 2'd2 : 2'(3 - ((k - 15) % 4));
            if (sym_ready) k++;
            step();
        end
        sym_valid = 1'b0;
        chk("bp_accepted", k, 30);
        chk("bp_count", dct_count, 15);
        chk("bp_sym_ready", sym_ready, 0);
        chk("bp_held_data", out_data, {4'd15, 30'h2AAAAAAA});
        out_ready = 1'b1;
        step();
        chk("bp_refill_valid", out_valid, 1);
        chk("bp_refill_count", dct_count, 0);
        step();
        chk("bp_drained", out_valid, 0);

        // Partial flush
        exp_q.push_back({4'd5, 30'h000003FF});
        sym_valid = 1'b1; sym = 2'd3;
        for (int i = 0; i < 5; i++) step();
        sym_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("pf_ending", test_ending, 1);
        chk("pf_sym_ready", sym_ready, 0);
        step();
        chk("pf_out_valid", out_valid, 1);
        chk("pf_count", dct_count, 0);
        chk("pf_not_ended", test_has_ended, 0);
        step();
        chk("pf_slot_empty", out_valid, 0);
        chk("pf_not_ended2", test_has_ended, 0);
        step();
        chk("pf_ended", test_has_ended, 1);

        // Empty flush
        reset = 1'b1; step(); reset = 1'b0;
        chk("ef_cleared", test_has_ended, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ef_ending", test_ending, 1);
        chk("ef_not_ended", test_has_ended, 0);
        step();
        chk("ef_ended", test_has_ended, 1);
        chk("ef_no_frame", out_valid, 0);

        // Flush coincident with a symbol
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b0;
        sym_valid = 1'b1; sym = 2'd1;
        for (int i = 0; i < 3; i++) step();
        sym = 2'd2; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fc_count", dct_count, 4);
        chk("fc_buffer", dct_buffer, 30'h56);
        chk("fc_sym_ready", sym_ready, 0);
        exp_q.push_back({4'd4, 30'h00000056});
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("fc_ended", test_has_ended, 1);
        chk("fc_sym_ready_end", sym_ready, 0);
        chk("fc_count_end", dct_count, 0);
        sym_valid = 1'b0;

        // Mid-frame reset discards partial frame
        reset = 1'b1; step(); reset = 1'b0;
        sym_valid = 1'b1; sym = 2'd3;
        for (int i = 0; i < 7; i++) step();
        chk("mr_count_pre", dct_count, 7);
        sym_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("mr_count", dct_count, 0);
        chk("mr_buffer", dct_buffer, 0);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        reset = 1'b0;
        step(); step();
        chk("mr_no_frame", out_valid, 0);

`ifdef OCI_DCT_DROP_CNT_EN
        // Fill slot and accumulator, then three refused offers
        out_ready = 1'b0;
        sym_valid = 1'b1; sym = 2'd1;
        for (int i = 0; i < 30; i++) step();
        chk("dc_zero", drop_count, 0);
        for (int i = 0; i < 3; i++) step();
        sym_valid = 1'b0;
        chk("dc_three", drop_count, 3);
        reset = 1'b1; step(); reset = 1'b0;
        chk("dc_reset", drop_count, 0);
`endif

        step(); step();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
